// File: rtl/pipe_reg_file_if.sv
// Bus bundle for pipe_reg_file: read ports, primary/auxiliary write ports,
// scoreboard reserve/flush controls and status outputs.
interface pipe_reg_file_if #(
  parameter int unsigned REG_BITS = 4,
  parameter int unsigned DATA_W   = 16
);
  logic [REG_BITS-1:0] rd1_addr;
  logic [REG_BITS-1:0] rd2_addr;
  logic [DATA_W-1:0]   rd1_data;
  logic [DATA_W-1:0]   rd2_data;
  logic                rd1_busy;
  logic                rd2_busy;
  logic [DATA_W-1:0]   aux_rd_data;
  logic                wr_en;
  logic [REG_BITS-1:0] wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                aux_wr_en;
  logic [DATA_W-1:0]   aux_wr_data;
  logic                rsv_en;
  logic [REG_BITS-1:0] rsv_addr;
  logic                flush;
  logic                busy_any;

  modport master (
    output rd1_addr, rd2_addr, wr_en, wr_addr, wr_data,
           aux_wr_en, aux_wr_data, rsv_en, rsv_addr, flush,
    input  rd1_data, rd2_data, rd1_busy, rd2_busy, aux_rd_data, busy_any
  );

  modport slave (
    input  rd1_addr, rd2_addr, wr_en, wr_addr, wr_data,
           aux_wr_en, aux_wr_data, rsv_en, rsv_addr, flush,
    output rd1_data, rd2_data, rd1_busy, rd2_busy, aux_rd_data, busy_any
  );
endinterface

// File: rtl/pipe_reg_file.sv
// Register file with per-register busy scoreboard and an auxiliary write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module pipe_reg_file #(
  parameter int unsigned REG_BITS = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned AUX_REG  = 0
) (
  input logic          clk,
  input logic          rst,
  pipe_reg_file_if.slave bus
);
  localparam int unsigned REG_CNT = 2 ** REG_BITS;
  localparam logic [REG_BITS-1:0] AUX_IDX = REG_BITS'(AUX_REG);

  logic [DATA_W-1:0]  regs_q [REG_CNT];
  logic [DATA_W-1:0]  regs_d [REG_CNT];
  logic [REG_CNT-1:0] busy_q;
  logic [REG_CNT-1:0] busy_d;
  logic               wr_ok;
  logic               aux_ok;
  logic               rsv_ok;
  logic               flush_ok;

  // Gating by rst keeps the bypass path from leaking writes during reset.
  assign wr_ok    = bus.wr_en     & rst;
  assign aux_ok   = bus.aux_wr_en & rst;
  assign rsv_ok   = bus.rsv_en    & rst;
  assign flush_ok = bus.flush     & rst;

  // Aux applied first so the primary port overwrites on an address collision;
  // reserve after clears, flush last, giving the required priorities.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (aux_ok) begin
      regs_d[AUX_IDX] = bus.aux_wr_data;
      busy_d[AUX_IDX] = 1'b0;
    end
    if (wr_ok) begin
      regs_d[bus.wr_addr] = bus.wr_data;
      busy_d[bus.wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
    if (flush_ok) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign bus.rd1_data    = regs_d[bus.rd1_addr];
  assign bus.rd2_data    = regs_d[bus.rd2_addr];
  assign bus.aux_rd_data = regs_d[AUX_IDX];
`else
  assign bus.rd1_data    = regs_q[bus.rd1_addr];
  assign bus.rd2_data    = regs_q[bus.rd2_addr];
  assign bus.aux_rd_data = regs_q[AUX_IDX];
`endif

  assign bus.rd1_busy = busy_q[bus.rd1_addr];
  assign bus.rd2_busy = busy_q[bus.rd2_addr];
  assign bus.busy_any = |busy_q;
endmodule

// File: tb/tb_pipe_reg_file.sv
// Directed self-checking bench for pipe_reg_file (AUX_REG = 0).
module tb_pipe_reg_file;
  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;

  pipe_reg_file_if #(.REG_BITS(4), .DATA_W(16)) bus ();

  pipe_reg_file #(.REG_BITS(4), .DATA_W(16), .AUX_REG(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.aux_wr_en   = 1'b0;
    bus.aux_wr_data = '0;
    bus.rsv_en      = 1'b0;
    bus.rsv_addr    = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'h1234;
    bus.rd1_addr = 4'd3;
    step();
    step();
    checks++;
    if (bus.rd1_data !== 16'h0000 || bus.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: rd1_data=%h busy_any=%b required 0000/0", bus.rd1_data, bus.busy_any);
    end
    @(negedge clk);
    rst = 1'b1;
    idle();
    step();
    checks++;
    if (bus.rd1_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release_data: rd1_data=%h required 0000", bus.rd1_data);
    end
    checks++;
    if (bus.busy_any !== 1'b0 || bus.aux_rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release_status: busy_any=%b aux=%h required 0/0000", bus.busy_any, bus.aux_rd_data);
    end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'hAAAA;
    bus.aux_wr_en = 1'b1; bus.aux_wr_data = 16'h5555;
    bus.rd1_addr = 4'd5;
    step();
    checks++;
    if (bus.rd1_data !== 16'hAAAA) begin
      errors++;
      $display("FAIL dual_reg5: rd1_data=%h required aaaa", bus.rd1_data);
    end
    checks++;
    if (bus.aux_rd_data !== 16'h5555) begin
      errors++;
      $display("FAIL dual_aux: aux_rd_data=%h required 5555", bus.aux_rd_data);
    end
    @(negedge clk);
    bus.wr_addr = 4'd0; bus.rd2_addr = 4'd0;
    step();
    checks++;
    if (bus.rd2_data !== 16'hAAAA || bus.aux_rd_data !== 16'hAAAA) begin
      errors++;
      $display("FAIL collide_primary_wins: rd2=%h aux=%h required aaaa/aaaa", bus.rd2_data, bus.aux_rd_data);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd7;
    bus.rd1_addr = 4'd7; bus.rd2_addr = 4'd5;
    step();
    checks++;
    if (bus.rd1_busy !== 1'b1 || bus.rd2_busy !== 1'b0 || bus.busy_any !== 1'b1) begin
      errors++;
      $display("FAIL rsv_set: rd1_busy=%b rd2_busy=%b busy_any=%b required 1/0/1", bus.rd1_busy, bus.rd2_busy, bus.busy_any);
    end
    @(negedge clk);
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h00FF;
    checks++;
    if (bus.rd1_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_no_bypass: rd1_busy=%b required 1", bus.rd1_busy);
    end
    step();
    checks++;
    if (bus.rd1_busy !== 1'b0 || bus.rd1_data !== 16'h00FF || bus.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL write_clears: busy=%b data=%h any=%b required 0/00ff/0", bus.rd1_busy, bus.rd1_data, bus.busy_any);
    end
    @(negedge clk);
    bus.wr_data = 16'h0123;
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd7;
    step();
    checks++;
    if (bus.rd1_busy !== 1'b1 || bus.rd1_data !== 16'h0123) begin
      errors++;
      $display("FAIL rsv_wins: busy=%b data=%h required 1/0123", bus.rd1_busy, bus.rd1_data);
    end
    @(negedge clk);
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h0777;
    step();
    @(negedge clk);
    idle();
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd0;
    bus.rd1_addr = 4'd0;
    step();
    @(negedge clk);
    idle();
    bus.aux_wr_en = 1'b1; bus.aux_wr_data = 16'hC0DE;
    step();
    checks++;
    if (bus.rd1_busy !== 1'b0 || bus.aux_rd_data !== 16'hC0DE || bus.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL aux_clears: busy=%b aux=%h any=%b required 0/c0de/0", bus.rd1_busy, bus.aux_rd_data, bus.busy_any);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_flush();
    logic [3:0] rsv_list [3];
    rsv_list = '{4'd2, 4'd4, 4'd9};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.rsv_en = 1'b1; bus.rsv_addr = rsv_list[i];
      step();
    end
    @(negedge clk);
    idle();
    bus.rd1_addr = 4'd4; bus.rd2_addr = 4'd9;
    #1;
    checks++;
    if (bus.rd1_busy !== 1'b1 || bus.rd2_busy !== 1'b1 || bus.busy_any !== 1'b1) begin
      errors++;
      $display("FAIL pre_flush: b4=%b b9=%b any=%b required 1/1/1", bus.rd1_busy, bus.rd2_busy, bus.busy_any);
    end
    bus.flush = 1'b1; bus.rsv_en = 1'b1; bus.rsv_addr = 4'd12;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd11; bus.wr_data = 16'hBEEF;
    step();
    bus.rd1_addr = 4'd11; bus.rd2_addr = 4'd12;
    #1;
    checks++;
    if (bus.busy_any !== 1'b0 || bus.rd2_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush: busy_any=%b b12=%b required 0/0", bus.busy_any, bus.rd2_busy);
    end
    checks++;
    if (bus.rd1_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL flush_write: rd1_data=%h required beef", bus.rd1_data);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_bypass();
    logic [15:0] exp;
`ifdef REGFILE_BYPASS_EN
    exp = 16'h6666;
`else
    exp = 16'h0000;
`endif
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd6; bus.wr_data = 16'h6666;
    bus.rd2_addr = 4'd6;
    #1;
    checks++;
    if (bus.rd2_data !== exp) begin
      errors++;
      $display("FAIL bypass_same_cycle: rd2_data=%h required %h", bus.rd2_data, exp);
    end
    step();
    checks++;
    if (bus.rd2_data !== 16'h6666) begin
      errors++;
      $display("FAIL bypass_next_cycle: rd2_data=%h required 6666", bus.rd2_data);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 16'hFFFF;
    step();
    @(negedge clk);
    idle();
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd1;
    bus.rd1_addr = 4'd1; bus.rd2_addr = 4'd5;
    step();
    @(negedge clk);
    idle();
    checks++;
    if (bus.rd1_data !== 16'hFFFF || bus.rd1_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: data=%h busy=%b required ffff/1", bus.rd1_data, bus.rd1_busy);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rd1_data !== 16'h0000 || bus.rd2_data !== 16'h0000 || bus.aux_rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset_data: rd1=%h rd2=%h aux=%h required 0000", bus.rd1_data, bus.rd2_data, bus.aux_rd_data);
    end
    checks++;
    if (bus.rd1_busy !== 1'b0 || bus.rd2_busy !== 1'b0 || bus.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_busy: b1=%b b2=%b any=%b required 0", bus.rd1_busy, bus.rd2_busy, bus.busy_any);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 16'h4321;
    step();
    checks++;
    if (bus.rd1_data !== 16'h4321) begin
      errors++;
      $display("FAIL resume_after_reset: rd1_data=%h required 4321", bus.rd1_data);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();
    bus.rd1_addr = '0;
    bus.rd2_addr = '0;
    test_reset();
    test_dual_write();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
